shift_unit_scheduler: RTL and testbench

Shares one combinational right-shift datapath (N-bit logical shift right of a by b) between NUM_REQ requesters. Each requester has a valid/ready request handshake. Arbitration is round-robin. The winner's operands are captured, the shifter output is registered, and the result is returned on a single valid/ready response channel tagged with the requester index. The block sits between ALU front-end request sources and the shift operator instance.

---
 rtl/shift_unit_scheduler.sv | 152 +++++++++++++++
 tb/tb_shift_unit_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_scheduler.sv
// shift_unit_scheduler: round-robin arbiter that shares one N-bit logical
// right shifter between NUM_REQ requesters and returns tagged results.
// Optional feature macro: SHIFT_SCHED_OOR_FLAG_EN adds rsp_oor, a registered
// flag marking results whose shift amount was >= N.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. Requesters hold req_valid/req_a/req_b
// stable until req_ready; the block holds rsp_valid/rsp_data/rsp_id stable
// until rsp_ready.
module shift_unit_scheduler #(
  parameter int N       = 8,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_data,
  output logic [ID_W-1:0]      rsp_id,
`ifdef SHIFT_SCHED_OOR_FLAG_EN
  output logic                 rsp_oor,
`endif
  output logic                 busy,
  output logic [1:0]           dbg_state,
  output logic [ID_W-1:0]      dbg_rr_ptr
);

  localparam int SH_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] rr_ptr;
  logic [N-1:0]    a_q, b_q;
  logic [ID_W-1:0] id_q;
  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [ID_W:0]   cand;
  logic            accept;
  logic            retire;
  logic            sh_oor;
  logic [N-1:0]    sh_out;
  logic [ID_W-1:0] rr_after_retire;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[ID_W-1:0];
      end
    end
  end

  // FSM next state and request-side outputs; req_ready only ever in IDLE.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && grant_found) begin
          req_ready[grant_id] = 1'b1;
          accept              = 1'b1;
          state_next          = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          retire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shared shifter: any amount with a bit at or above log2(N) flushes to zero.
  always_comb begin
    sh_oor = |b_q[N-1:SH_W];
    sh_out = sh_oor ? '0 : (a_q >> b_q[SH_W-1:0]);
  end

  // Pointer moves to the requester after the one just retired.
  always_comb begin
    rr_after_retire = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : (id_q + ID_W'(1));
  end

  // State, operand capture, result register and fairness pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_q  <= req_a[grant_id*N +: N];
        b_q  <= req_b[grant_id*N +: N];
        id_q <= grant_id;
      end
      if (state == EXEC) begin
        rsp_data  <= sh_out;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end
      if (retire) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= rr_after_retire;
      end
    end
  end

`ifdef SHIFT_SCHED_OOR_FLAG_EN
  // Out-of-range flag travels with rsp_data and is frozen the same way.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_oor <= 1'b0;
    end else if (state == EXEC) begin
      rsp_oor <= sh_oor;
    end
  end
`endif

  assign busy       = (state != IDLE);
  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_shift_unit_scheduler.sv
// Directed testbench for shift_unit_scheduler (N=8, NUM_REQ=2).
module tb_shift_unit_scheduler;
  localparam int N       = 8;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_a;
  logic [NUM_REQ*N-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [N-1:0]         rsp_data;
  logic [ID_W-1:0]      rsp_id;
`ifdef SHIFT_SCHED_OOR_FLAG_EN
  logic                 rsp_oor;
`endif
  logic                 busy;
  logic [1:0]           dbg_state;
  logic [ID_W-1:0]      dbg_rr_ptr;

  int n_cmp = 0;
  int n_err = 0;

  shift_unit_scheduler #(.N(N), .NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
`ifdef SHIFT_SCHED_OOR_FLAG_EN
    .rsp_oor    (rsp_oor),
`endif
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // Clock and reset-free clock generation
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one full transaction with rsp_ready high: grant, EXEC, RESP, retire.
  task automatic run_txn(input string tag, input logic [1:0] exp_rdy,
                         input logic [7:0] exp_data, input logic exp_id,
                         input logic exp_oor);
    rsp_ready = 1'b1;
    #1;
    chk({tag, ".grant"}, req_ready, exp_rdy);
    tick();
    chk({tag, ".exec_busy"}, busy, 1);
    chk({tag, ".exec_rdy"}, req_ready, 0);
    chk({tag, ".exec_valid"}, rsp_valid, 0);
    tick();
    chk({tag, ".rsp_valid"}, rsp_valid, 1);
    chk({tag, ".rsp_data"}, rsp_data, exp_data);
    chk({tag, ".rsp_id"}, rsp_id, exp_id);
    chk({tag, ".resp_rdy"}, req_ready, 0);
`ifdef SHIFT_SCHED_OOR_FLAG_EN
    chk({tag, ".rsp_oor"}, rsp_oor, exp_oor);
`else
    if (exp_oor !== 1'bx) begin end
`endif
    tick();
    chk({tag, ".retired"}, rsp_valid, 0);
    chk({tag, ".busy_low"}, busy, 0);
  endtask

  initial begin
    // Reset: request presented during reset must not be accepted.
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    req_a     = {8'h00, 8'hB4};
    req_b     = {8'h00, 8'h02};
    tick();
    chk("rst.req_ready", req_ready, 0);
    tick();
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.rsp_data", rsp_data, 0);
    chk("rst.rsp_id", rsp_id, 0);
    chk("rst.state", dbg_state, 0);
    chk("rst.rr_ptr", dbg_rr_ptr, 0);
    rst       = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("idle.req_ready", req_ready, 0);
    tick();
    chk("idle.busy", busy, 0);
    chk("idle.rsp_valid", rsp_valid, 0);

    // Single request from req0.
    req_valid = 2'b01;
    req_a     = {8'h00, 8'hB4};
    req_b     = {8'h00, 8'h02};
    run_txn("single", 2'b01, 8'h2D, 1'b0, 1'b0);
    chk("single.rr_ptr", dbg_rr_ptr, 1);

    // Out-of-range amount from req1, then in-range.
    req_valid = 2'b10;
    req_a     = {8'hFF, 8'h00};
    req_b     = {8'h08, 8'h00};
    run_txn("oor", 2'b10, 8'h00, 1'b1, 1'b1);
    chk("oor.rr_ptr", dbg_rr_ptr, 0);
    req_b     = {8'h03, 8'h00};
    run_txn("inrange", 2'b10, 8'h1F, 1'b1, 1'b0);

    // Round-robin with both requesters continuously valid.
    req_valid = 2'b11;
    req_a     = {8'h80, 8'hFF};
    req_b     = {8'h07, 8'h01};
    run_txn("rr0", 2'b01, 8'h7F, 1'b0, 1'b0);
    run_txn("rr1", 2'b10, 8'h01, 1'b1, 1'b0);
    run_txn("rr2", 2'b01, 8'h7F, 1'b0, 1'b0);
    run_txn("rr3", 2'b10, 8'h01, 1'b1, 1'b0);
    chk("rr.rr_ptr", dbg_rr_ptr, 0);

    // Back-pressure: hold rsp_ready low while both requesters stay valid.
    rsp_ready = 1'b0;
    #1;
    chk("bp.grant", req_ready, 2'b01);
    tick();
    tick();
    chk("bp.rsp_valid", rsp_valid, 1);
    chk("bp.rsp_data", rsp_data, 8'h7F);
    chk("bp.rsp_id", rsp_id, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.hold_valid", rsp_valid, 1);
      chk("bp.hold_data", rsp_data, 8'h7F);
      chk("bp.hold_id", rsp_id, 0);
      chk("bp.hold_rdy", req_ready, 0);
      chk("bp.hold_state", dbg_state, 2);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp.retired", rsp_valid, 0);
    chk("bp.rr_ptr", dbg_rr_ptr, 1);
    #1;
    chk("bp.next_grant", req_ready, 2'b10);

    // Reset while req1's request is in EXEC.
    tick();
    chk("midrst.exec", dbg_state, 1);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 2'b00;
    chk("midrst.state", dbg_state, 0);
    chk("midrst.rr_ptr", dbg_rr_ptr, 0);
    chk("midrst.rsp_valid", rsp_valid, 0);
    chk("midrst.busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst.no_rsp", rsp_valid, 0);
    end
    req_valid = 2'b10;
    req_a     = {8'h80, 8'h00};
    req_b     = {8'h07, 8'h00};
    run_txn("midrst.req1", 2'b10, 8'h01, 1'b1, 1'b0);
    chk("midrst.rr_after", dbg_rr_ptr, 0);

    // Shift-amount boundaries: b=0 passes a through, a high bit of b flushes.
    req_valid = 2'b01;
    req_a     = {8'h00, 8'hA5};
    req_b     = {8'h00, 8'h00};
    run_txn("b_zero", 2'b01, 8'hA5, 1'b0, 1'b0);
    req_a     = {8'h00, 8'hFF};
    req_b     = {8'h00, 8'h82};
    run_txn("b_high", 2'b01, 8'h00, 1'b0, 1'b1);
    req_valid = 2'b00;
    tick();
    chk("end.idle", dbg_state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
